// File: rtl/rx_phy_pkg.sv
// rtl/rx_phy_pkg.sv - shared RX PHY constants, comma patterns and aligner state encoding
package rx_phy_pkg;

    // Comma prefix (abcdeif) of K28.1/K28.5/K28.7 in both running disparities.
    localparam logic [6:0] COMMA_POS = 7'b1111100;
    localparam logic [6:0] COMMA_NEG = 7'b0000011;

    // Full K28.5 code groups, bit 0 = 8b/10b bit 'a'.
    localparam logic [9:0] K28_5_RDN = 10'b0101111100;
    localparam logic [9:0] K28_5_RDP = 10'b1010000011;

    typedef enum logic [1:0] {
        ALIGN_SEARCH = 2'd0,
        ALIGN_CHECK  = 2'd1,
        ALIGN_LOCKED = 2'd2
    } align_state_e;

    function automatic logic is_comma(input logic [6:0] cand);
        return (cand == COMMA_POS) || (cand == COMMA_NEG);
    endfunction

endpackage

// File: rtl/comma_detect.sv
// rtl/comma_detect.sv - combinational comma search over all 10 bit offsets of a 20-bit window
module comma_detect
    import rx_phy_pkg::*;
(
    input  logic [19:0] win_i,
    output logic [9:0]  hit_o
);

    // Offset k looks at the 7 comma bits starting at window bit k.
    always_comb begin
        hit_o = '0;
        for (int k = 0; k < 10; k++) begin
            hit_o[k] = is_comma(win_i[k +: 7]);
        end
    end

endmodule

// File: rtl/comma_symbol_aligner.sv
// rtl/comma_symbol_aligner.sv - K28.5 comma hunt, symbol lock FSM and aligned symbol output
module comma_symbol_aligner
    import rx_phy_pkg::*;
#(
    parameter int DATA_WIDTH   = 10,
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    output logic                  comma_det,
    output logic                  symbol_lock,
    output logic [3:0]            align_offset,
    output logic                  realign_pulse
);

    localparam int CNT_W  = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_COUNT + 1);

    align_state_e            state_q;
    logic [DATA_WIDTH-1:0]   prev_q;
    logic [3:0]              offset_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [MISS_W-1:0]       miss_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    data_out_valid_q;
    logic                    comma_det_q;
    logic                    symbol_lock_q;
    logic                    realign_q;

    logic [2*DATA_WIDTH-1:0] win;
    logic [9:0]              hit_vec;
    logic                    any_hit;
    logic                    hit_cur;
    logic [3:0]              lowest_k;
    logic [3:0]              sel_k;
    logic [DATA_WIDTH-1:0]   aligned_sym;

    // Bit 0 of the window is the oldest received bit.
    assign win         = {data_in, prev_q};
    assign any_hit     = |hit_vec;
    assign hit_cur     = hit_vec[offset_q];
    assign aligned_sym = win[offset_q +: DATA_WIDTH];
    assign sel_k       = hit_cur ? offset_q : lowest_k;

    comma_detect u_comma_detect (
        .win_i (win),
        .hit_o (hit_vec)
    );

    // Lowest-offset hit, used when the current offset is not among the hits.
    always_comb begin
        lowest_k = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (hit_vec[k]) begin
                lowest_k = 4'(k);
            end
        end
    end

    // Lock FSM with counters and registered outputs; nothing advances on stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ALIGN_SEARCH;
            prev_q           <= '0;
            offset_q         <= '0;
            cnt_q            <= '0;
            miss_q           <= '0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
            comma_det_q      <= 1'b0;
            symbol_lock_q    <= 1'b0;
            realign_q        <= 1'b0;
        end else begin
            realign_q        <= 1'b0;
            data_out_valid_q <= 1'b0;
            comma_det_q      <= 1'b0;
            if (data_valid) begin
                prev_q           <= data_in;
                data_out_q       <= aligned_sym;
                data_out_valid_q <= (state_q == ALIGN_LOCKED);
                comma_det_q      <= hit_cur && (state_q == ALIGN_LOCKED);
                case (state_q)
                    ALIGN_SEARCH: begin
                        if (any_hit) begin
                            offset_q <= sel_k;
                            cnt_q    <= CNT_W'(1);
                            if (LOCK_COUNT == 1) begin
                                state_q          <= ALIGN_LOCKED;
                                symbol_lock_q    <= 1'b1;
                                data_out_valid_q <= 1'b1;
                                comma_det_q      <= hit_cur;
                            end else begin
                                state_q <= ALIGN_CHECK;
                            end
                        end
                    end
                    ALIGN_CHECK: begin
                        if (hit_cur) begin
                            if (cnt_q >= CNT_W'(LOCK_COUNT - 1)) begin
                                cnt_q            <= CNT_W'(LOCK_COUNT);
                                miss_q           <= '0;
                                state_q          <= ALIGN_LOCKED;
                                symbol_lock_q    <= 1'b1;
                                data_out_valid_q <= 1'b1;
                                comma_det_q      <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end else if (any_hit) begin
                            offset_q <= lowest_k;
                            cnt_q    <= CNT_W'(1);
                        end
                    end
                    ALIGN_LOCKED: begin
                        if (hit_cur) begin
                            miss_q <= '0;
                        end else if (any_hit) begin
                            if (miss_q >= MISS_W'(UNLOCK_COUNT - 1)) begin
                                // Offset is kept; SEARCH replaces it on its first hit.
                                miss_q           <= '0;
                                state_q          <= ALIGN_SEARCH;
                                symbol_lock_q    <= 1'b0;
                                data_out_valid_q <= 1'b0;
                                comma_det_q      <= 1'b0;
                                realign_q        <= 1'b1;
                            end else begin
                                miss_q <= miss_q + MISS_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_q <= ALIGN_SEARCH;
                    end
                endcase
            end
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = data_out_valid_q;
    assign comma_det      = comma_det_q;
    assign symbol_lock    = symbol_lock_q;
    assign align_offset   = offset_q;
    assign realign_pulse  = realign_q;

endmodule

// File: tb/tb_comma_symbol_aligner.sv
// tb/tb_comma_symbol_aligner.sv - scoreboard bench for comma_symbol_aligner
module tb_comma_symbol_aligner;

    localparam int LOCK   = 3;
    localparam int UNLOCK = 4;
    localparam logic [9:0] K_N = 10'h17C;
    localparam logic [9:0] K_P = 10'h283;
    localparam logic [9:0] D_A = 10'h2AA;
    localparam logic [9:0] D_B = 10'h155;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] data_in = '0;
    logic       data_valid = 1'b0;
    logic [9:0] data_out;
    logic       data_out_valid;
    logic       comma_det;
    logic       symbol_lock;
    logic [3:0] align_offset;
    logic       realign_pulse;

    always #5 clk = ~clk;

    comma_symbol_aligner #(
        .DATA_WIDTH   (10),
        .LOCK_COUNT   (LOCK),
        .UNLOCK_COUNT (UNLOCK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_valid     (data_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .comma_det      (comma_det),
        .symbol_lock    (symbol_lock),
        .align_offset   (align_offset),
        .realign_pulse  (realign_pulse)
    );

    typedef struct {
        logic [9:0] data;
        logic       vld;
        logic       comma;
        logic       lock;
        logic [3:0] off;
        logic       realign;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   bq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   realign_seen = 0;

    // Reference model: the bit stream as seen through a sliding 20-bit window.
    logic [9:0] m_prev, m_data;
    int         m_off, m_run, m_foreign;
    bit         m_locked;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] hits_of(input logic [19:0] w);
        logic [9:0] h;
        logic [6:0] c;
        h = '0;
        for (int k = 0; k < 10; k++) begin
            c = 7'(w >> k);
            h[k] = (c == 7'b1111100) || (c == 7'b0000011);
        end
        return h;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_data = '0; m_off = 0; m_run = 0; m_foreign = 0; m_locked = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit v, input logic [9:0] d);
        exp_t e;
        logic [19:0] w;
        logic [9:0]  h;
        bit own, lost;
        int lowest;
        lost = 0;
        own  = 0;
        if (v) begin
            w = {d, m_prev};
            m_prev = d;
            h = hits_of(w);
            own = h[m_off];
            m_data = 10'(w >> m_off);
            lowest = -1;
            for (int k = 0; k < 10; k++) if (h[k] && lowest < 0) lowest = k;
            if (m_locked) begin
                if (own) m_foreign = 0;
                else if (h != 0) begin
                    m_foreign++;
                    if (m_foreign == UNLOCK) begin
                        m_locked = 0; m_run = 0; m_foreign = 0; lost = 1;
                    end
                end
            end else if (m_run == 0) begin
                if (h != 0) begin
                    if (!own) m_off = lowest;
                    m_run = 1;
                    if (m_run == LOCK) m_locked = 1;
                end
            end else begin
                if (own) begin
                    m_run++;
                    if (m_run == LOCK) m_locked = 1;
                end else if (h != 0) begin
                    m_off = lowest;
                    m_run = 1;
                end
            end
        end
        e.data    = m_data;
        e.vld     = v && m_locked;
        e.comma   = v && own && m_locked;
        e.lock    = m_locked;
        e.off     = 4'(m_off);
        e.realign = lost;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [9:0] d);
        @(negedge clk);
        data_in    = d;
        data_valid = v;
        model_step(v, d);
    endtask

    task automatic push_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) bq.push_back(s[i]);
    endtask

    task automatic push_bits(input int n, input logic [9:0] b);
        for (int i = 0; i < n; i++) bq.push_back(b[i]);
    endtask

    function automatic logic [9:0] pick_sym();
        case ($urandom_range(3))
            0:       return K_N;
            1:       return K_P;
            2:       return D_A;
            default: return D_B;
        endcase
    endfunction

    // Sends whole words while at least 10 bits remain; the remainder carries over.
    task automatic run_stream(input int stall_pct, input bit alt, input int max_words);
        logic [9:0] wd;
        int n;
        n = 0;
        while (bq.size() >= 10 && n < max_words) begin
            if (alt || ($urandom_range(99) < stall_pct)) drive(1'b0, 10'($urandom));
            for (int i = 0; i < 10; i++) wd[i] = bq.pop_front();
            drive(1'b1, wd);
            n++;
        end
    endtask

    task automatic settle();
        drive(1'b0, '0);
        @(posedge clk);
        #3;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        data_valid = 1'b0;
        model_reset();
        bq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preamble();
        push_sym(D_A);
        push_sym(D_B);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_data_out_valid"}, data_out_valid, 0);
        chk({tag, "_comma_det"}, comma_det, 0);
        chk({tag, "_symbol_lock"}, symbol_lock, 0);
        chk({tag, "_align_offset"}, align_offset, 0);
        chk({tag, "_realign_pulse"}, realign_pulse, 0);
    endtask

    // Monitor: every driven cycle has one expected entry, compared after the edge.
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("data_out", data_out, mon_e.data);
            chk("data_out_valid", data_out_valid, mon_e.vld);
            chk("comma_det", comma_det, mon_e.comma);
            chk("symbol_lock", symbol_lock, mon_e.lock);
            chk("align_offset", align_offset, mon_e.off);
            chk("realign_pulse", realign_pulse, mon_e.realign);
        end
        if (realign_pulse) realign_seen++;
    end

    initial begin
        int r0;
        logic [9:0] rs;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Aligned K28.5 stream at offset 0.
        preamble();
        repeat (4) push_sym(K_N);
        repeat (3) push_sym(D_A);
        run_stream(0, 0, 1000);
        settle();
        chk("t1_lock", symbol_lock, 1);
        chk("t1_offset", align_offset, 0);

        // Same kind of stream displaced by 3 bits.
        apply_reset();
        preamble();
        push_bits(3, 10'b101);
        repeat (4) push_sym(K_N);
        push_sym(D_A); push_sym(D_B); push_sym(K_P); push_sym(D_A); push_sym(K_N); push_sym(D_B);
        run_stream(0, 0, 1000);
        settle();
        chk("t2_lock", symbol_lock, 1);
        chk("t2_offset", align_offset, 3);

        // Four foreign commas at offset 7 drop lock, then relock there.
        r0 = realign_seen;
        push_bits(4, 10'b0101);
        repeat (7) push_sym(K_N);
        repeat (3) push_sym(D_A);
        run_stream(0, 0, 1000);
        settle();
        chk("t3_realign_count", realign_seen - r0, 1);
        chk("t3_lock", symbol_lock, 1);
        chk("t3_offset", align_offset, 7);

        // Offset change in CHECK restarts the count.
        apply_reset();
        r0 = realign_seen;
        preamble();
        push_bits(2, 10'b01);
        push_sym(K_N); push_sym(K_N);
        push_bits(3, 10'b101);
        repeat (3) push_sym(K_N);
        push_sym(D_A); push_sym(D_B); push_sym(D_A);
        run_stream(0, 0, 1000);
        settle();
        chk("t4_lock", symbol_lock, 1);
        chk("t4_offset", align_offset, 5);
        chk("t4_no_realign", realign_seen - r0, 0);

        // Locked stream with alternate stall cycles.
        repeat (30) push_sym(pick_sym());
        run_stream(0, 1, 1000);
        settle();
        chk("t5_lock", symbol_lock, 1);
        chk("t5_offset", align_offset, 5);

        // Asynchronous reset mid-stream, then reacquire.
        repeat (20) push_sym(pick_sym());
        run_stream(0, 0, 8);
        @(posedge clk);
        #3 rst_n = 1'b0;
        data_valid = 1'b0;
        #1 chk_all_zero("t6_async");
        model_reset();
        bq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        preamble();
        repeat (4) push_sym(K_N);
        repeat (3) push_sym(D_B);
        run_stream(0, 0, 1000);
        settle();
        chk("t6_relock", symbol_lock, 1);
        chk("t6_offset", align_offset, 0);

        // Randomized stream with phase slips, arbitrary words and stalls.
        for (int i = 0; i < 200; i++) begin
            rs = 10'($urandom);
            case ($urandom_range(9))
                0, 1, 2: push_sym(K_N);
                3, 4:    push_sym(K_P);
                5:       push_sym(D_A);
                6:       push_sym(D_B);
                7, 8:    push_sym(rs);
                default: begin
                    push_bits(int'($urandom_range(1, 9)), rs);
                    push_sym(K_N);
                end
            endcase
        end
        run_stream(30, 0, 1000);
        settle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
